generic_fifo_arbiter: RTL and testbench

GENERIC_FIFO_ARBITER -- requirements
Module: generic_fifo_arbiter

---
 rtl/generic_fifo_arbiter.sv | 102 ++++++++++
 tb/tb_generic_fifo_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_arbiter.sv
// Packet-locked round-robin arbiter draining NUM_REQ FIFOs into one valid/ready stream.
// A grant is held from first beat to EOP; data is muxed from the registered FIFO outputs.
module generic_fifo_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int EOP_BIT    = DATA_WIDTH-1,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset_poweron_n,
   input  logic                          clear,
   input  logic [NUM_REQ-1:0]            req_enable,
   input  logic [NUM_REQ-1:0]            req_empty,
   output logic [NUM_REQ-1:0]            req_read,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_read_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_source,
   output logic                          out_eop,
   output logic                          busy
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            state;
   logic [ID_WIDTH-1:0]   grant_id;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [DATA_WIDTH-1:0] words [NUM_REQ];

   logic                  can_issue;
   logic                  eop_hs;
   logic                  arbitrate;
   logic                  rr_found;
   logic [ID_WIDTH-1:0]   rr_sel;
   int                    rr_idx;
   logic [ID_WIDTH-1:0]   sel;
   logic                  sel_ok;
   logic                  issue;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = req_read_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign out_data  = words[out_source];
   assign out_eop   = out_data[EOP_BIT];
   assign busy      = (state == ST_LOCKED);
   assign can_issue = ~out_valid | out_ready;
   assign eop_hs    = out_valid & out_ready & out_eop;
   assign arbitrate = (state == ST_IDLE) | eop_hs;

   // Walk downward so the closest requester after last_grant is the one left standing.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      rr_idx   = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         rr_idx = (int'(last_grant) + i) % NUM_REQ;
         if (req_enable[rr_idx] && !req_empty[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = ID_WIDTH'(rr_idx);
         end
      end
   end

   always_comb begin
      sel    = grant_id;
      sel_ok = ~req_empty[grant_id];
      if (arbitrate) begin
         sel    = rr_sel;
         sel_ok = rr_found;
      end
   end

   assign issue = can_issue & sel_ok & ~clear & reset_poweron_n;

   always_comb begin
      req_read = '0;
      if (issue) req_read[sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_poweron_n || clear) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         out_source <= '0;
         grant_id   <= '0;
         last_grant <= ID_WIDTH'(NUM_REQ-1);
      end else if (issue) begin
         state      <= ST_LOCKED;
         out_valid  <= 1'b1;
         out_source <= sel;
         grant_id   <= sel;
         last_grant <= sel;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (eop_hs) state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_generic_fifo_arbiter.sv
// Directed bench for generic_fifo_arbiter: table of first-grant cases plus packet sequences,
// with behavioural FIFOs (registered read data) and a beat monitor.
module tb_generic_fifo_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset_poweron_n = 1'b0;
   logic            clear = 1'b0;
   logic [N-1:0]    req_enable = '0;
   logic [N-1:0]    req_empty;
   logic [N-1:0]    req_read;
   logic [N*DW-1:0] req_read_data;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_source;
   logic            out_eop;
   logic            busy;

   generic_fifo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_poweron_n(reset_poweron_n), .clear(clear),
      .req_enable(req_enable), .req_empty(req_empty), .req_read(req_read),
      .req_read_data(req_read_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_source(out_source), .out_eop(out_eop), .busy(busy)
   );

   always #5 clk = ~clk;

   // FIFO models: initial owns wp, the clocked block owns rp and rdata.
   logic [31:0] mem [N][256];
   int          wp [N] = '{default: 0};
   int          rp [N] = '{default: 0};
   logic [31:0] rdata [N];
   logic        flush = 1'b0;
   int          proto_err = 0;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_empty[i] = (rp[i] == wp[i]);
         req_read_data[i*DW +: DW] = rdata[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (flush) rp[i] <= wp[i];
         else if (req_read[i] && rp[i] != wp[i]) begin
            rdata[i] <= mem[i][rp[i]];
            rp[i]    <= rp[i] + 1;
         end
      end
      if ((req_read & req_empty) != '0 || $countones(req_read) > 1)
         proto_err <= proto_err + 1;
   end

   logic [1:0]  beat_src [256];
   logic [31:0] beat_data [256];
   int          nbeats = 0;

   always @(posedge clk) begin
      if (reset_poweron_n && out_valid && out_ready) begin
         beat_src[nbeats]  <= out_source;
         beat_data[nbeats] <= out_data;
         nbeats            <= nbeats + 1;
      end
   end

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] w(input int src, input int seq, input bit eop);
      return {eop, 19'b0, 4'(src), 8'(seq)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input int src, input logic [31:0] d);
      mem[src][wp[src]] = d;
      wp[src]++;
   endtask

   task automatic push_pkt(input int src, input int n, input int base);
      for (int k = 0; k < n; k++) push_word(src, w(src, base + k, k == n - 1));
   endtask

   task automatic do_reset(input bit do_flush);
      reset_poweron_n = 1'b0;
      flush = do_flush;
      #1;
      chk("read_in_reset", req_read, 0);
      @(negedge clk);
      reset_poweron_n = 1'b1;
      flush = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_source", out_source, 0);
   endtask

   task automatic wait_beats(input int target, input int budget);
      int c;
      c = 0;
      while (nbeats < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("beat_count", nbeats, target);
   endtask

   task automatic chk_beat(input int idx, input int src, input int seq, input bit eop);
      chk("beat_src", beat_src[idx], src);
      chk("beat_data", beat_data[idx], w(src, seq, eop));
   endtask

   typedef struct {
      logic [3:0] en;
      logic [3:0] ne;
      logic [3:0] exp;
   } vec_t;

   vec_t vt [7];

   initial begin
      int base;
      logic [3:0] exp_rd [5];
      logic       exp_v  [5];

      vt[0] = '{4'b1111, 4'b1111, 4'b0001};
      vt[1] = '{4'b1010, 4'b1111, 4'b0010};
      vt[2] = '{4'b1111, 4'b0100, 4'b0100};
      vt[3] = '{4'b1000, 4'b1111, 4'b1000};
      vt[4] = '{4'b0000, 4'b1111, 4'b0000};
      vt[5] = '{4'b1111, 4'b0000, 4'b0000};
      vt[6] = '{4'b0110, 4'b1001, 4'b0000};

      @(negedge clk);
      @(negedge clk);

      // first grant after reset: lowest enabled non-empty requester
      for (int v = 0; v < 7; v++) begin
         do_reset(1'b1);
         req_enable = vt[v].en;
         for (int s = 0; s < N; s++)
            if (vt[v].ne[s]) push_word(s, w(s, 0, 1));
         #1;
         chk("rr_first", req_read, vt[v].exp);
         @(negedge clk);
      end

      // single 3-word packet from requester 2
      do_reset(1'b1);
      req_enable = 4'b1111;
      out_ready = 1'b1;
      base = nbeats;
      push_pkt(2, 3, 0);
      exp_rd = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("pkt3_read", req_read, exp_rd[k]);
         chk("pkt3_valid", out_valid, exp_v[k]);
         chk("pkt3_busy", busy, exp_v[k]);
         if (k == 3) chk("pkt3_eop", out_eop, 1);
         @(negedge clk);
      end
      chk("pkt3_beats", nbeats - base, 3);
      for (int k = 0; k < 3; k++) chk_beat(base + k, 2, k, k == 2);

      // three 2-word packets back to back in index order
      do_reset(1'b1);
      base = nbeats;
      push_pkt(0, 2, 0);
      push_pkt(1, 2, 0);
      push_pkt(3, 2, 0);
      repeat (7) @(negedge clk);
      chk("b2b_beats", nbeats - base, 6);
      for (int p = 0; p < 3; p++)
         for (int k = 0; k < 2; k++)
            chk_beat(base + p*2 + k, (p == 2) ? 3 : p, k, k == 1);

      // backpressure mid-packet, enable dropped while locked
      do_reset(1'b1);
      base = nbeats;
      push_pkt(0, 4, 0);
      @(negedge clk);
      req_enable = 4'b0000;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, w(0, 1, 0));
         chk("stall_src", out_source, 0);
         chk("stall_read", req_read, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_beats(base + 4, 20);
      for (int k = 0; k < 4; k++) chk_beat(base + k, 0, k, k == 3);
      repeat (3) @(negedge clk);
      chk("stall_no_dup", nbeats - base, 4);

      // locked requester runs dry; other requester must wait for EOP
      do_reset(1'b1);
      req_enable = 4'b1111;
      base = nbeats;
      push_word(1, w(1, 0, 0));
      push_word(1, w(1, 1, 0));
      @(negedge clk);
      push_word(0, w(0, 0, 1));
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("lock_no_read0", req_read[0], 0);
         chk("lock_busy", busy, 1);
         @(negedge clk);
      end
      push_word(1, w(1, 2, 1));
      #1;
      chk("lock_resume", req_read, 4'b0010);
      wait_beats(base + 4, 20);
      chk_beat(base + 0, 1, 0, 0);
      chk_beat(base + 1, 1, 1, 0);
      chk_beat(base + 2, 1, 2, 1);
      chk_beat(base + 3, 0, 0, 1);

      // reset mid-packet without draining FIFOs, then clear mid-packet
      do_reset(1'b1);
      push_pkt(2, 3, 0);
      @(negedge clk);
      @(negedge clk);
      push_word(1, w(1, 0, 1));
      push_word(3, w(3, 0, 1));
      reset_poweron_n = 1'b0;
      #1;
      chk("midrst_read", req_read, 0);
      @(negedge clk);
      reset_poweron_n = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_grant", req_read, 4'b0010);
      @(negedge clk);
      clear = 1'b1;
      #1;
      chk("clear_read", req_read, 0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("clear_valid", out_valid, 0);
      chk("clear_busy", busy, 0);
      chk("clear_grant", req_read, 4'b0100);

      // masked requesters, alternation per packet
      do_reset(1'b1);
      req_enable = 4'b1010;
      base = nbeats;
      for (int s = 0; s < N; s++) begin
         push_pkt(s, 2, 0);
         push_pkt(s, 2, 2);
      end
      wait_beats(base + 8, 40);
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 2; k++)
            chk_beat(base + p*2 + k, (p % 2 == 0) ? 1 : 3, (p / 2)*2 + k, k == 1);
      repeat (3) @(negedge clk);
      chk("mask_no_extra", nbeats - base, 8);

      chk("fifo_protocol", proto_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
